// File: rtl/muldiv_unit_pkg.sv
// Shared HI/LO unit definitions: op encodings, latencies and the multiply helper.
// Used by muldiv_unit and div_iter.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MUL_LAT  = 4;
  localparam int DIV_ITER = 32;

  // Full 64-bit product; sign-extending both operands makes the low 64 bits
  // of the unsigned multiply equal to the signed product.
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Iterative restoring radix-2 divider: one quotient bit per clock on operand
// magnitudes, signs restored on the outputs. Present only with MULDIV_DIVIDE_EN.
module div_iter
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dsr_reg;
  logic [5:0]  cnt_reg;
  logic        active_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        fits;

  // The dividend shifts out of quo_reg from the top while quotient bits
  // enter at the bottom, so one register serves both roles.
  assign partial = {rem_reg, quo_reg[31]};
  assign diff    = partial - {1'b0, dsr_reg};
  assign fits    = ~diff[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
    end else if (start) begin
      quo_reg    <= (sgn && dividend[31]) ? -dividend : dividend;
      dsr_reg    <= (sgn && divisor[31]) ? -divisor : divisor;
      rem_reg    <= '0;
      cnt_reg    <= 6'(DIV_ITER);
      active_reg <= 1'b1;
      q_neg_reg  <= sgn && (dividend[31] ^ divisor[31]);
      r_neg_reg  <= sgn && dividend[31];
    end else if (active_reg && cnt_reg != 6'd0) begin
      rem_reg <= fits ? diff[31:0] : partial[31:0];
      quo_reg <= {quo_reg[30:0], fits};
      cnt_reg <= cnt_reg - 6'd1;
    end
  end

  assign done      = active_reg && (cnt_reg == 6'd0);
  assign quotient  = q_neg_reg ? -quo_reg : quo_reg;
  assign remainder = r_neg_reg ? -rem_reg : rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO unit for the EX stage: multi-cycle multiply, optional iterative divide
// (macro MULDIV_DIVIDE_EN), MTHI/MTLO, and the stall request for the hazard unit.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_use_ID,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        sign_reg;
  logic [63:0] prod_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic idle;
  logic accept_mul;
  logic accept_mthi;
  logic accept_mtlo;

  assign idle        = (state_reg == ST_IDLE);
  assign accept_mul  = idle && start && (op == OP_MULT || op == OP_MULTU);
  assign accept_mthi = idle && start && (op == OP_MTHI);
  assign accept_mtlo = idle && start && (op == OP_MTLO);

`ifdef MULDIV_DIVIDE_EN
  logic        accept_div;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign accept_div = idle && start && (op == OP_DIV || op == OP_DIVU);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div),
    .sgn       (op == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sign_reg  <= 1'b0;
      prod_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_mthi) hi_reg <= a;
          if (accept_mtlo) lo_reg <= a;
          if (accept_mul) begin
            a_reg     <= a;
            b_reg     <= b;
            sign_reg  <= (op == OP_MULT);
            cnt_reg   <= 6'(MUL_LAT - 1);
            state_reg <= ST_MUL;
          end
`ifdef MULDIV_DIVIDE_EN
          if (accept_div) begin
            a_reg     <= a;
            b_reg     <= b;
            sign_reg  <= (op == OP_DIV);
            cnt_reg   <= 6'(DIV_ITER - 1);
            state_reg <= ST_DIV;
          end
`endif
        end
        ST_MUL: begin
          // Product is formed once from the latched operands; the remaining
          // cycles only pad out the fixed multiply latency.
          if (cnt_reg == 6'(MUL_LAT - 1)) prod_reg <= mul64(a_reg, b_reg, sign_reg);
          if (cnt_reg == 6'd0) begin
            {hi_reg, lo_reg} <= prod_reg;
            state_reg        <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 6'd1;
          end
        end
`ifdef MULDIV_DIVIDE_EN
        ST_DIV: begin
          if (cnt_reg == 6'd0) state_reg <= ST_FIX;
          else cnt_reg <= cnt_reg - 6'd1;
        end
        ST_FIX: begin
          if (div_done) begin
            // Divide by zero reports all-ones quotient and the dividend as
            // remainder regardless of signedness.
            if (b_reg == 32'd0) begin
              hi_reg <= a_reg;
              lo_reg <= 32'hFFFF_FFFF;
            end else begin
              hi_reg <= div_rem;
              lo_reg <= div_quo;
            end
            state_reg <= ST_IDLE;
          end
        end
`else
        ST_DIV, ST_FIX: state_reg <= ST_IDLE;
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = !idle;
  assign stall_req = busy && hilo_use_ID;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against
// an arithmetic reference model; honours MULDIV_DIVIDE_EN like the design.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_use_ID;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hilo_use_ID (hilo_use_ID),
    .busy        (busy),
    .stall_req   (stall_req),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: what HI/LO must hold after the op, and how many cycles busy stays high.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint sx, sy, sp;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    eh = hi_m;
    el = lo_m;
    lat = 0;
    case (o)
      OP_MULT:  begin sp = sx * sy; {eh, el} = sp; lat = 4; end
      OP_MULTU: begin up = ux * uy; {eh, el} = up; lat = 4; end
      OP_MTHI:  eh = x;
      OP_MTLO:  el = x;
`ifdef MULDIV_DIVIDE_EN
      OP_DIV: begin
        lat = 33;
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin el = 32'(sx / sy); eh = 32'(sx % sy); end
      end
      OP_DIVU: begin
        lat = 33;
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin el = 32'(ux / uy); eh = 32'(ux % uy); end
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op; optionally hold a second start (MTHI) high for the whole busy period.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic use_id, input logic second);
    logic [31:0] eh, el;
    int lat, n;
    model(o, x, y, eh, el, lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; hilo_use_ID = use_id;
    @(posedge clk); #1;
    start = second; op = OP_MTHI; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk({tag, " stall"}, {63'd0, stall_req}, {63'd0, use_id});
      chk({tag, " hold"}, {hi, lo}, {hi_m, lo_m});
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hilo"}, {hi, lo}, {eh, el});
    chk({tag, " stall_idle"}, {63'd0, stall_req}, 64'd0);
    $display("op %0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d (%s)", o, x, y, hi, lo, n, tag);
    hi_m = eh;
    lo_m = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; hilo_use_ID = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset stall", {63'd0, stall_req}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    run_op("mtlo", OP_MTLO, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    run_op("mult neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult max", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu /0", OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op("div /0", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div 8/2", OP_DIV, 32'd8, 32'd2, 1'b0, 1'b0);
    run_op("divu big", OP_DIVU, 32'hFFFF_FFF0, 32'd3, 1'b0, 1'b0);
    run_op("div stall", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b1);
    run_op("mult stall", OP_MULT, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 1'b1);
    run_op("unused6", 3'd6, 32'hAAAA_5555, 32'd1, 1'b0, 1'b0);
    run_op("unused7", 3'd7, 32'h5555_AAAA, 32'd1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op("random", ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort a long operation with an asynchronous reset pulse mid-cycle.
    run_op("pre mthi", OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    run_op("pre mtlo", OP_MTLO, 32'h0BAD_CAFE, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef MULDIV_DIVIDE_EN
    start = 1'b1; op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; hilo_use_ID = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
`else
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9; hilo_use_ID = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
`endif
    #2; rst = 1'b1; #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort stall", {63'd0, stall_req}, 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    $display("reset pulse mid-op -> busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk); rst = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    run_op("post mtlo", OP_MTLO, 32'd5, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
